usb_up_arbiter: RTL and testbench

- Packet-granular scheduler for the FX2 upload channel (up_req/up_grant/up_dat/up_fin).
- Shares the channel between two show-ahead source FIFOs: src0 carries IQ samples, src1 carries status/telemetry.
- Round-robin selection, one fixed-length packet per grant; sits between the source FIFOs and the fx2 interface block.
- Adds an inter-packet gap, a completion watchdog, and per-source packet counters.

---
 rtl/usb_pkg.sv | 19 +
 rtl/usb_rr_pick2.sv | 25 ++
 rtl/usb_up_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_usb_up_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared definitions for the FX2 upload-channel arbiter.
//   usb_state_e   : arbiter FSM states (idle, packet transfer, inter-packet gap)
//   PKT_WORDS_DEF : default packet length in 16-bit words
//   SRC_IQ        : source index of the IQ sample FIFO
//   SRC_STAT      : source index of the status/telemetry FIFO
package usb_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StXfer = 2'd1,
      StGap  = 2'd2
   } usb_state_e;

   localparam int unsigned PKT_WORDS_DEF = 256;

   localparam logic SRC_IQ   = 1'b0;
   localparam logic SRC_STAT = 1'b1;

endpackage

// File: rtl/usb_rr_pick2.sv
// Combinational two-way round-robin picker. The pointer register lives in the
// parent so it only advances when a pick is actually taken.
//   req0_i, req1_i : source eligibility
//   rr_ptr_i       : source granted last time
//   valid_o        : at least one source eligible
//   pick_o         : chosen source index
module usb_rr_pick2 (
   input  logic req0_i,
   input  logic req1_i,
   input  logic rr_ptr_i,
   output logic valid_o,
   output logic pick_o
);

   always_comb begin
      valid_o = req0_i | req1_i;
      if (req0_i && req1_i) begin
         // Contention: the source that did not go last wins.
         pick_o = ~rr_ptr_i;
      end else begin
         pick_o = req1_i;
      end
   end

endmodule

// File: rtl/usb_up_arbiter.sv
// Packet-granular round-robin scheduler for the FX2 upload channel. Shares the
// channel between two show-ahead FIFOs (src0: IQ samples, src1: status), one
// fixed-length packet per grant, with a forced inter-packet gap, a completion
// watchdog and per-source packet counters.
//   clk_24m, rst_n          : clock, async active-low reset
//   en                      : upload enable
//   srcN_level/dat/rd       : source FIFO level, show-ahead word, read strobe
//   up_req/grant/dat/fin    : fx2 upload handshake
//   active_src              : source of current or last packet
//   pkt_cnt0, pkt_cnt1      : completed packets per source (wrapping)
//   timeout_err/overrun_err : sticky error flags
module usb_up_arbiter
   import usb_pkg::*;
#(
   parameter int unsigned PKT_WORDS = PKT_WORDS_DEF,
   parameter int unsigned LVL_W     = 10,
   parameter int unsigned GAP_CYC   = 4,
   parameter int unsigned TIMEOUT   = 65535
) (
   input  logic             clk_24m,
   input  logic             rst_n,
   input  logic             en,
   input  logic [LVL_W-1:0] src0_level,
   input  logic [15:0]      src0_dat,
   output logic             src0_rd,
   input  logic [LVL_W-1:0] src1_level,
   input  logic [15:0]      src1_dat,
   output logic             src1_rd,
   output logic             up_req,
   input  logic             up_grant,
   output logic [15:0]      up_dat,
   input  logic             up_fin,
   output logic             active_src,
   output logic [15:0]      pkt_cnt0,
   output logic [15:0]      pkt_cnt1,
   output logic             timeout_err,
   output logic             overrun_err
);

   localparam int unsigned WC_W  = $clog2(PKT_WORDS) + 1;
   localparam int unsigned GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

   localparam logic [LVL_W-1:0] PKT_LVL  = LVL_W'(PKT_WORDS);
   localparam logic [WC_W-1:0]  PKT_WC   = WC_W'(PKT_WORDS);
   localparam logic [15:0]      WD_LAST  = 16'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

   usb_state_e       state_q, state_d;
   logic             up_req_q, up_req_d;
   logic             active_q, active_d;
   logic             rr_q, rr_d;
   logic [WC_W-1:0]  word_cnt_q, word_cnt_d;
   logic [15:0]      wd_q, wd_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic [15:0]      pkt_cnt0_q, pkt_cnt0_d;
   logic [15:0]      pkt_cnt1_q, pkt_cnt1_d;
   logic             timeout_q, timeout_d;
   logic             overrun_q, overrun_d;

   logic elig0, elig1;
   logic pick_valid, pick_src;
   logic words_left;

   assign elig0 = (src0_level >= PKT_LVL);
   assign elig1 = (src1_level >= PKT_LVL);

   usb_rr_pick2 u_pick (
      .req0_i   (elig0),
      .req1_i   (elig1),
      .rr_ptr_i (rr_q),
      .valid_o  (pick_valid),
      .pick_o   (pick_src)
   );

   assign words_left = (word_cnt_q < PKT_WC);

   always_comb begin
      state_d    = state_q;
      up_req_d   = up_req_q;
      active_d   = active_q;
      rr_d       = rr_q;
      word_cnt_d = word_cnt_q;
      wd_d       = wd_q;
      gap_d      = gap_q;
      pkt_cnt0_d = pkt_cnt0_q;
      pkt_cnt1_d = pkt_cnt1_q;
      timeout_d  = timeout_q;
      overrun_d  = overrun_q;
      src0_rd    = 1'b0;
      src1_rd    = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (en && pick_valid) begin
               state_d    = StXfer;
               up_req_d   = 1'b1;
               active_d   = pick_src;
               rr_d       = pick_src;
               word_cnt_d = '0;
               wd_d       = '0;
            end
         end

         StXfer: begin
            // A grant with the final word in the same cycle as up_fin is still
            // read here before the packet is closed below.
            if (up_grant) begin
               if (words_left) begin
                  word_cnt_d = word_cnt_q + 1'b1;
                  src0_rd    = (active_q == SRC_IQ);
                  src1_rd    = (active_q == SRC_STAT);
               end else begin
                  overrun_d = 1'b1;
               end
            end
            wd_d = wd_q + 16'd1;
            if (up_fin) begin
               state_d    = StGap;
               up_req_d   = 1'b0;
               word_cnt_d = '0;
               gap_d      = '0;
               if (active_q == SRC_STAT) begin
                  pkt_cnt1_d = pkt_cnt1_q + 16'd1;
               end else begin
                  pkt_cnt0_d = pkt_cnt0_q + 16'd1;
               end
            end else if (wd_q == WD_LAST) begin
               // Abandoned packet: not counted as completed.
               state_d    = StGap;
               up_req_d   = 1'b0;
               word_cnt_d = '0;
               gap_d      = '0;
               timeout_d  = 1'b1;
            end
         end

         StGap: begin
            if (gap_q == GAP_LAST) begin
               state_d = StIdle;
            end else begin
               gap_d = gap_q + 1'b1;
            end
         end

         default: begin
            state_d  = StIdle;
            up_req_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_24m or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         up_req_q   <= 1'b0;
         active_q   <= 1'b0;
         rr_q       <= 1'b1;
         word_cnt_q <= '0;
         wd_q       <= '0;
         gap_q      <= '0;
         pkt_cnt0_q <= '0;
         pkt_cnt1_q <= '0;
         timeout_q  <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         up_req_q   <= up_req_d;
         active_q   <= active_d;
         rr_q       <= rr_d;
         word_cnt_q <= word_cnt_d;
         wd_q       <= wd_d;
         gap_q      <= gap_d;
         pkt_cnt0_q <= pkt_cnt0_d;
         pkt_cnt1_q <= pkt_cnt1_d;
         timeout_q  <= timeout_d;
         overrun_q  <= overrun_d;
      end
   end

   assign up_dat      = active_q ? src1_dat : src0_dat;
   assign up_req      = up_req_q;
   assign active_src  = active_q;
   assign pkt_cnt0    = pkt_cnt0_q;
   assign pkt_cnt1    = pkt_cnt1_q;
   assign timeout_err = timeout_q;
   assign overrun_err = overrun_q;

endmodule

// File: tb/tb_usb_up_arbiter.sv
// Self-checking bench for usb_up_arbiter: models both show-ahead FIFOs and the
// fx2 side, keeps a queue of expected packet sources and its own word-index
// model of each FIFO to predict every presented word.
module tb_usb_up_arbiter;

   localparam int unsigned PKT_WORDS = 256;
   localparam int unsigned LVL_W     = 10;
   localparam int unsigned GAP_CYC   = 4;
   localparam int unsigned TIMEOUT   = 1000;

   logic             clk_24m = 1'b0;
   logic             rst_n = 1'b0;
   logic             en = 1'b0;
   logic             up_grant = 1'b0;
   logic             up_fin = 1'b0;
   logic [LVL_W-1:0] src0_level = '0;
   logic [LVL_W-1:0] src1_level = '0;
   logic [15:0]      src0_dat, src1_dat, up_dat, pkt_cnt0, pkt_cnt1;
   logic             src0_rd, src1_rd, up_req, active_src, timeout_err, overrun_err;

   int idx0 = 0;
   int idx1 = 0;
   int e_idx0 = 0;
   int e_idx1 = 0;
   int n_chk = 0;
   int n_fail = 0;
   logic exp_src_q[$];

   always #5 clk_24m = ~clk_24m;

   usb_up_arbiter #(
      .PKT_WORDS (PKT_WORDS),
      .LVL_W     (LVL_W),
      .GAP_CYC   (GAP_CYC),
      .TIMEOUT   (TIMEOUT)
   ) dut (
      .clk_24m     (clk_24m),
      .rst_n       (rst_n),
      .en          (en),
      .src0_level  (src0_level),
      .src0_dat    (src0_dat),
      .src0_rd     (src0_rd),
      .src1_level  (src1_level),
      .src1_dat    (src1_dat),
      .src1_rd     (src1_rd),
      .up_req      (up_req),
      .up_grant    (up_grant),
      .up_dat      (up_dat),
      .up_fin      (up_fin),
      .active_src  (active_src),
      .pkt_cnt0    (pkt_cnt0),
      .pkt_cnt1    (pkt_cnt1),
      .timeout_err (timeout_err),
      .overrun_err (overrun_err)
   );

   // Show-ahead FIFO models: head word is a function of words already read.
   assign src0_dat = 16'(idx0);
   assign src1_dat = 16'h8000 | 16'(idx1 & 32'h7fff);

   always @(posedge clk_24m) begin
      if (src0_rd) idx0 <= idx0 + 1;
      if (src1_rd) idx1 <= idx1 + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge clk_24m) begin
      if (rst_n) chk("rd_outside_xfer", 32'((src0_rd | src1_rd) & ~up_req), 32'd0);
   end

   task automatic reset_checks();
      chk("rst_up_req", 32'(up_req), 32'd0);
      chk("rst_active_src", 32'(active_src), 32'd0);
      chk("rst_pkt_cnt0", 32'(pkt_cnt0), 32'd0);
      chk("rst_pkt_cnt1", 32'(pkt_cnt1), 32'd0);
      chk("rst_timeout_err", 32'(timeout_err), 32'd0);
      chk("rst_overrun_err", 32'(overrun_err), 32'd0);
      chk("rst_rd", 32'(src0_rd | src1_rd), 32'd0);
   endtask

   task automatic wait_req(input int limit, output int waited, output bit ok);
      waited = 0;
      ok = 1'b0;
      while (waited < limit && !ok) begin
         @(negedge clk_24m);
         waited++;
         ok = up_req;
      end
   endtask

   task automatic count_req_high(input int cycles, output int hi);
      hi = 0;
      for (int i = 0; i < cycles; i++) begin
         @(negedge clk_24m);
         if (up_req) hi++;
      end
   endtask

   // fin_mode: 0 no up_fin, 1 up_fin after the grants, 2 up_fin with last grant.
   // waited: negedges from entry until up_req was seen (measures the gap).
   task automatic run_packet(input int n_grants, input int fin_mode, input int drop_en_at,
                             output int waited);
      bit   ok;
      logic exp_src;
      int   base0, base1, exp_reads;
      wait_req(100, waited, ok);
      chk("req_seen", 32'(ok), 32'd1);
      if (!ok) return;
      if (exp_src_q.size() == 0) begin
         chk("scoreboard_empty", 32'(exp_src_q.size()), 32'd1);
         return;
      end
      exp_src = exp_src_q.pop_front();
      chk("active_src", 32'(active_src), 32'(exp_src));
      base0 = idx0;
      base1 = idx1;
      for (int g = 0; g < n_grants; g++) begin
         @(posedge clk_24m);
         #1;
         up_grant = 1'b1;
         if (g == drop_en_at) en = 1'b0;
         if (fin_mode == 2 && g == n_grants - 1) up_fin = 1'b1;
         @(negedge clk_24m);
         if (g < PKT_WORDS) begin
            chk("rd_sel", 32'(exp_src ? src1_rd : src0_rd), 32'd1);
            chk("up_dat", 32'(up_dat),
                exp_src ? 32'(16'h8000 | 16'(e_idx1)) : 32'(16'(e_idx0)));
            if (exp_src) e_idx1++;
            else e_idx0++;
         end else begin
            chk("rd_overrun", 32'(src0_rd | src1_rd), 32'd0);
         end
         chk("rd_other", 32'(exp_src ? src0_rd : src1_rd), 32'd0);
      end
      @(posedge clk_24m);
      #1;
      up_grant = 1'b0;
      up_fin = 1'b0;
      if (fin_mode == 1) begin
         up_fin = 1'b1;
         @(posedge clk_24m);
         #1;
         up_fin = 1'b0;
      end
      if (fin_mode != 0) begin
         @(negedge clk_24m);
         chk("req_drop", 32'(up_req), 32'd0);
      end
      exp_reads = (n_grants < int'(PKT_WORDS)) ? n_grants : int'(PKT_WORDS);
      chk("reads", 32'(exp_src ? idx1 - base1 : idx0 - base0), 32'(exp_reads));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "global timeout");
   end

   initial begin
      int w, hi, base;
      bit ok;

      // Reset state
      repeat (3) @(posedge clk_24m);
      #1;
      reset_checks();
      rst_n = 1'b1;

      // Single source, single packet
      @(posedge clk_24m);
      #1;
      src0_level = 10'd300;
      en = 1'b1;
      exp_src_q.push_back(1'b0);
      @(negedge clk_24m);
      chk("req_before_arb", 32'(up_req), 32'd0);
      @(posedge clk_24m);
      #1;
      chk("req_latency", 32'(up_req), 32'd1);
      run_packet(256, 1, -1, w);
      src0_level = '0;
      chk("t1_pkt_cnt0", 32'(pkt_cnt0), 32'd1);
      chk("t1_pkt_cnt1", 32'(pkt_cnt1), 32'd0);

      // Both sources full: alternation from a fresh pointer
      rst_n = 1'b0;
      repeat (2) @(posedge clk_24m);
      #1;
      rst_n = 1'b1;
      src0_level = 10'd512;
      src1_level = 10'd512;
      exp_src_q.push_back(1'b0);
      exp_src_q.push_back(1'b1);
      exp_src_q.push_back(1'b0);
      exp_src_q.push_back(1'b1);
      for (int k = 0; k < 4; k++) begin
         run_packet(256, 1, -1, w);
         // Gap cycles plus the idle arbitration cycle separate the packets.
         if (k > 0) chk("gap_len", 32'(w >= int'(GAP_CYC) && w <= int'(GAP_CYC) + 1), 32'd1);
      end
      chk("t2_pkt_cnt0", 32'(pkt_cnt0), 32'd2);
      chk("t2_pkt_cnt1", 32'(pkt_cnt1), 32'd2);

      // Enable low blocks arbitration; dropping it mid-packet lets it finish
      en = 1'b0;
      count_req_high(50, hi);
      chk("en_off_no_req", 32'(hi), 32'd0);
      @(posedge clk_24m);
      #1;
      en = 1'b1;
      exp_src_q.push_back(1'b0);
      run_packet(256, 1, 100, w);
      count_req_high(50, hi);
      chk("en_drop_no_req", 32'(hi), 32'd0);
      chk("t3_pkt_cnt0", 32'(pkt_cnt0), 32'd3);

      // Watchdog: no grants, no up_fin
      src1_level = '0;
      src0_level = 10'd300;
      en = 1'b1;
      exp_src_q.push_back(1'b0);
      wait_req(100, w, ok);
      chk("to_req_seen", 32'(ok), 32'd1);
      chk("to_active_src", 32'(active_src), 32'(exp_src_q.pop_front()));
      base = idx0;
      hi = 0;
      while (up_req && hi < 2000) begin
         hi++;
         @(negedge clk_24m);
      end
      chk("to_xfer_len", 32'(hi), 32'(TIMEOUT));
      chk("to_flag", 32'(timeout_err), 32'd1);
      chk("to_pkt_cnt0", 32'(pkt_cnt0), 32'd3);
      chk("to_no_reads", 32'(idx0 - base), 32'd0);
      exp_src_q.push_back(1'b0);
      run_packet(256, 1, -1, w);
      chk("to_resume_pkt", 32'(pkt_cnt0), 32'd4);

      // Overrun: fx2 grants 260 words
      chk("ovr_flag_before", 32'(overrun_err), 32'd0);
      exp_src_q.push_back(1'b0);
      run_packet(260, 1, -1, w);
      chk("ovr_flag", 32'(overrun_err), 32'd1);
      chk("ovr_pkt_cnt0", 32'(pkt_cnt0), 32'd5);

      // up_fin together with the final grant
      exp_src_q.push_back(1'b0);
      run_packet(256, 2, -1, w);
      chk("fin_last_pkt_cnt0", 32'(pkt_cnt0), 32'd6);
      chk("ovr_sticky", 32'(overrun_err), 32'd1);
      chk("to_sticky", 32'(timeout_err), 32'd1);

      // Reset in the middle of a packet
      exp_src_q.push_back(1'b0);
      run_packet(50, 0, -1, w);
      chk("mid_req_high", 32'(up_req), 32'd1);
      rst_n = 1'b0;
      #1;
      reset_checks();
      @(posedge clk_24m);
      #1;
      rst_n = 1'b1;
      src0_level = 10'd512;
      src1_level = 10'd512;
      exp_src_q.push_back(1'b0);
      run_packet(256, 1, -1, w);
      chk("post_rst_pkt_cnt0", 32'(pkt_cnt0), 32'd1);
      chk("post_rst_pkt_cnt1", 32'(pkt_cnt1), 32'd0);
      chk("sb_drained", 32'(exp_src_q.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
